// File: rtl/muldiv_unit_pkg.sv
// Shared types and helpers for the multiply/divide engine.
package muldiv_unit_pkg;

  localparam int unsigned XLEN = 32;

  // Operation selector, produced by the decoder from the funct field.
  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  // Engine control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  // Signed variants treat operands as two's complement.
  function automatic logic op_is_signed(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Magnitude for signed operands, raw value for unsigned ones.
  // The most negative value maps onto itself, which is the correct
  // unsigned magnitude 2^31.
  function automatic logic [XLEN-1:0] mag_of(input logic [XLEN-1:0] x,
                                             input logic            is_signed);
    return (is_signed && x[XLEN-1]) ? ((XLEN)'(0) - x) : x;
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Iterative unsigned restoring divider: one quotient bit per step on a
// combined {remainder, quotient} register. Sign handling lives in the parent.
module muldiv_unit_div_core #(
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,     // load dividend/divisor, clear counter
  input  logic        step_i,      // perform one restoring step
  input  logic        clear_i,     // abort: counter back to 0
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quot_o,      // quotient after the current step
  output logic [31:0] rem_o,       // remainder after the current step
  output logic        last_o       // current step is the final one
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  logic [63:0]   rq_q;
  logic [31:0]   divisor_q;
  logic [CW-1:0] cnt_q;

  logic [32:0]   shifted_d;
  logic [32:0]   diff_d;
  logic [63:0]   rq_d;

  // Shift the partial remainder left by one, try subtracting the divisor,
  // and keep the difference only when it did not borrow. Because the partial
  // remainder stays below the divisor (or below 2^k after k steps when the
  // divisor is zero), bit 32 of the difference is a reliable borrow flag.
  always_comb begin
    shifted_d = {rq_q[63:32], rq_q[31]};
    diff_d    = shifted_d - {1'b0, divisor_q};
    rq_d      = rq_q;
    if (!diff_d[32]) begin
      rq_d = {diff_d[31:0], rq_q[30:0], 1'b1};
    end else begin
      rq_d = {shifted_d[31:0], rq_q[30:0], 1'b0};
    end
  end

  assign quot_o = rq_d[31:0];
  assign rem_o  = rq_d[63:32];
  assign last_o = step_i && (cnt_q == CW'(ITERS - 1));

  // Operand load, per-cycle step and iteration counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rq_q      <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (start_i) begin
      rq_q      <= {32'd0, dividend_i};
      divisor_q <= divisor_i;
      cnt_q     <= '0;
    end else if (step_i) begin
      rq_q  <= rq_d;
      cnt_q <= last_o ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide engine for the execute stage. Stalls the
// pipeline while computing and presents {hi, lo} with a one-cycle done pulse.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  md_state_t   state_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;
  logic [31:0] a_mag_q;
  logic [31:0] b_mag_q;
  logic        sign_a_q;
  logic        sign_b_q;

  muldiv_op_t  op_in;
  logic        signed_in;
  logic [31:0] a_mag_in;
  logic [31:0] b_mag_in;
  logic        accept;
  logic        div_start;
  logic        div_step;

  logic [31:0] div_quot;
  logic [31:0] div_rem;
  logic        div_last;

  logic [63:0] prod_raw;
  logic [63:0] prod_d;
  logic [31:0] quot_d;
  logic [31:0] rem_d;

  assign op_in     = muldiv_op_t'(op_i);
  assign signed_in = op_is_signed(op_in);
  assign a_mag_in  = mag_of(a_i, signed_in);
  assign b_mag_in  = mag_of(b_i, signed_in);

  // A flush in the same cycle suppresses the start.
  assign accept    = (state_q == ST_IDLE) && valid_i && !flush_i;
  assign div_start = accept && op_is_div(op_in);
  assign div_step  = (state_q == ST_DIV);

  muldiv_unit_div_core #(
    .ITERS(DIV_ITERS)
  ) u_div_core (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .step_i     (div_step),
    .clear_i    (flush_i),
    .dividend_i (a_mag_in),
    .divisor_i  (b_mag_in),
    .quot_o     (div_quot),
    .rem_o      (div_rem),
    .last_o     (div_last)
  );

  // Unsigned magnitude product, then the signed fixups for product,
  // quotient (sign(a)^sign(b)) and remainder (sign(a)).
  always_comb begin
    prod_raw = {32'd0, a_mag_q} * {32'd0, b_mag_q};
    prod_d   = (sign_a_q ^ sign_b_q) ? (64'd0 - prod_raw) : prod_raw;
    quot_d   = (sign_a_q ^ sign_b_q) ? (32'd0 - div_quot) : div_quot;
    rem_d    = sign_a_q ? (32'd0 - div_rem) : div_rem;
  end

  // Control FSM with registered result and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (valid_i) begin
              a_mag_q  <= a_mag_in;
              b_mag_q  <= b_mag_in;
              sign_a_q <= signed_in && a_i[31];
              sign_b_q <= signed_in && b_i[31];
              state_q  <= op_is_div(op_in) ? ST_DIV : ST_MUL;
            end
          end
          ST_MUL: begin
            hi_q    <= prod_d[63:32];
            lo_q    <= prod_d[31:0];
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
          ST_DIV: begin
            if (div_last) begin
              hi_q    <= rem_d;
              lo_q    <= quot_d;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
          // valid_i here still belongs to the departing instruction.
          ST_DONE: state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign stall_o = accept || (state_q == ST_MUL) || (state_q == ST_DIV);
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide engine in the execute stage.
- Consumes decoded MULT/MULTU/DIV/DIVU operands from the execute stage. Holds execute (and, through the hazard unit, all upstream stages) stalled while it computes.
- Delivers the 64-bit {hi, lo} result that the execute stage carries downstream to the hilo write port.

Parameters:
- DIV_ITERS, 32, number of radix-2 division iterations; equals the operand width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- valid_i  input  1  execute stage holds a mul/div instruction this cycle
- op_i  input  2  muldiv_op_t: MULT, MULTU, DIV, DIVU
- a_i  input  32  rs operand, already forwarded
- b_i  input  32  rt operand, already forwarded
- flush_i  input  1  execute-stage flush (exception/eret); aborts the operation
- stall_o  output  1  to hazard unit; execute must hold
- busy_o  output  1  state is not IDLE
- done_o  output  1  one-cycle pulse; hi_o/lo_o are valid this cycle
- hi_o  output  32  product[63:32] or remainder
- lo_o  output  32  product[31:0] or quotient

Behaviour:
- One clock. Reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset values: state IDLE, hi_o=0, lo_o=0, done_o=0, busy_o=0, stall_o=0, iteration counter=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - valid_i & !flush_i: latch op, |a|, |b| and the sign bits.
  - |x| means magnitude for signed ops and the raw value for unsigned ops.
  - Go to MUL for MULT/MULTU, to DIV for DIV/DIVU.
- MUL: register the 64-bit product, sign-corrected for MULT, into hi_o/lo_o; go to DONE.
- DIV: one restoring step per cycle on a 64-bit {rem, quot} register.
  - Counter runs 0..DIV_ITERS-1.
  - On the last step, write the sign-corrected quotient to lo_o and remainder to hi_o, counter returns to 0, go to DONE.
- DONE: done_o=1; go to IDLE unconditionally. valid_i is ignored in this cycle: it still belongs to the instruction that is leaving execute.
- stall_o = (state==IDLE & valid_i & !flush_i) | state==MUL | state==DIV. stall_o=0 in DONE, so the instruction advances with the result.
- busy_o = state!=IDLE.
- Latency from the accept edge: MUL* done_o is high 2 cycles later; DIV* done_o is high DIV_ITERS+1 = 33 cycles later.
- Signed fixups:
  - Quotient is negated iff sign(a)^sign(b).
  - Remainder is negated iff sign(a).
  - Product is negated iff sign(a)^sign(b).
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. No trap.
- Divide by zero (deterministic, falls out of the restoring algorithm):
  - DIVU: lo=0xFFFFFFFF, hi=a.
  - DIV: quotient = -1 if a>=0, else +1; hi=a.
- flush_i in any state: next state IDLE, counter cleared, done_o stays low, hi_o/lo_o keep their previous values.
- flush_i together with valid_i in IDLE: flush wins and nothing starts.
- Reset mid-operation: immediate return to the reset values; no done pulse.
- hi_o/lo_o keep the last result until the next result is written.
- Multiply is a single registered 32x32 multiply with no internal iteration.

Decomposition:
- Shared package (mips.svh): muldiv_op_t enum (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and the muldiv state enum.
- Decoder mapping from funct codes 0x18/0x19/0x1A/0x1B to muldiv_op_t lives with the decode logic, not in this block.
- One sub-module, div_core:
  - Iterative unsigned restoring divider: start, dividend, divisor in; quot, rem, last-step flag out.
  - Sign handling stays in muldiv_unit.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> done_o 2 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall_o high for exactly 2 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> done_o 33 cycles after accept; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- Boundaries:
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
  - DIVU 5/0 -> lo=0xFFFFFFFF, hi=5.
  - DIV -7/0 -> lo=1, hi=0xFFFFFFF9.
- Start DIV, assert flush_i at iteration 10 -> IDLE next cycle, no done_o, hi/lo unchanged. A new MULTU 6*7 issued the following cycle gives lo=42.
- Back-to-back: DIVU then MULT with valid_i held through DONE -> the DONE-cycle valid_i is ignored; the second op is accepted only the cycle after DONE. Reset asserted mid-DIV -> all outputs 0 next cycle.
